picoblaze_io_hub: RTL and testbench

PICOBLAZE_IO_HUB -- requirements
Module: picoblaze_io_hub

---
 rtl/picoblaze_io_pkg.sv | 24 ++
 rtl/picoblaze_irq_ctrl.sv | 60 ++++++
 rtl/picoblaze_io_hub.sv | 83 ++++++++
 tb/tb_picoblaze_io_hub.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/picoblaze_io_pkg.sv
// Shared constants for the PicoBlaze I/O hub: register offsets, parameter limits
// and the interrupt controller state type.
package picoblaze_io_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_MASK   = 2'd1;
  localparam logic [1:0] REG_CLEAR  = 2'd2;
  localparam logic [1:0] REG_EOI    = 2'd3;

  localparam logic [7:0] ADDR_STATUS = 8'h80;
  localparam logic [7:0] ADDR_MASK   = 8'h81;

  localparam int unsigned MAX_N_IN  = 7;
  localparam int unsigned MAX_N_OUT = 7;
  localparam int unsigned MAX_N_K   = 4;
  localparam int unsigned MAX_N_IRQ = 8;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_REQ,
    IRQ_SERVICE
  } irq_state_e;

endpackage

// File: rtl/picoblaze_irq_ctrl.sv
// Interrupt controller: rising-edge capture into pending bits, enable mask,
// and the IDLE/REQ/SERVICE handshake with the processor.
module picoblaze_irq_ctrl
  import picoblaze_io_pkg::*;
#(
  parameter int unsigned N_IRQ = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_IRQ-1:0] i_irq_req,
  input  logic [N_IRQ-1:0] i_wdata,
  input  logic             i_mask_we,
  input  logic             i_clear_we,
  input  logic             i_eoi_we,
  input  logic             i_ack,
  output logic [N_IRQ-1:0] o_pending,
  output logic [N_IRQ-1:0] o_mask,
  output logic             o_interrupt
);

  logic [N_IRQ-1:0] r_prev;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_mask;
  logic [N_IRQ-1:0] w_edge;
  logic [N_IRQ-1:0] w_clr;
  irq_state_e       r_state;
  irq_state_e       w_state_next;

  assign w_edge = i_irq_req & ~r_prev;
  assign w_clr  = i_clear_we ? i_wdata : '0;

  // prev tracks the input even in reset, so a level held across release is not an edge
  always_ff @(posedge i_clk) begin
    r_prev <= i_irq_req;
    if (i_rst) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_state   <= IRQ_IDLE;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_edge;
      if (i_mask_we) r_mask <= i_wdata;
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IRQ_IDLE:    if ((r_pending & r_mask) != '0) w_state_next = IRQ_REQ;
      IRQ_REQ:     if (i_ack) w_state_next = IRQ_SERVICE;
      IRQ_SERVICE: if (i_eoi_we) w_state_next = IRQ_IDLE;
      default:     w_state_next = IRQ_IDLE;
    endcase
  end

  assign o_pending   = r_pending;
  assign o_mask      = r_mask;
  assign o_interrupt = (r_state == IRQ_REQ);

endmodule

// File: rtl/picoblaze_io_hub.sv
// PicoBlaze I/O hub: one-hot port decode for general and constant-optimised
// outputs, registered read mux, and the interrupt register block.
module picoblaze_io_hub
  import picoblaze_io_pkg::*;
#(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 4,
  parameter int unsigned N_K   = 2,
  parameter int unsigned N_IRQ = 4
) (
  input  logic               clk_i,
  input  logic               cpu_rst_i,
  input  logic [7:0]         port_id_i,
  input  logic [7:0]         out_port_i,
  input  logic               write_strobe_i,
  input  logic               k_write_strobe_i,
  input  logic               read_strobe_i,
  output logic [7:0]         in_port_o,
  output logic               interrupt_o,
  input  logic               interrupt_ack_i,
  input  logic [N_IN*8-1:0]  in_ports_i,
  output logic [N_OUT*8-1:0] out_ports_o,
  output logic [N_K*8-1:0]   k_ports_o,
  input  logic [N_IRQ-1:0]   irq_req_i
);

  logic [N_OUT*8-1:0] r_out_ports;
  logic [N_K*8-1:0]   r_k_ports;
  logic [7:0]         r_in_port;
  logic [7:0]         w_rd_data;
  logic               w_gen_we;
  logic               w_reg_we;
  logic [N_IRQ-1:0]   w_pending;
  logic [N_IRQ-1:0]   w_mask;
  logic               w_unused_rd;

  // Reads are unconditional each cycle; the strobe carries no information here.
  assign w_unused_rd = read_strobe_i;

  assign w_gen_we = write_strobe_i & ~port_id_i[7];
  assign w_reg_we = write_strobe_i &  port_id_i[7];

  always_ff @(posedge clk_i) begin
    if (cpu_rst_i) begin
      r_out_ports <= '0;
      r_k_ports   <= '0;
      r_in_port   <= '0;
    end else begin
      for (int unsigned i = 0; i < N_OUT; i++)
        if (w_gen_we && port_id_i[i]) r_out_ports[8*i +: 8] <= out_port_i;
      for (int unsigned j = 0; j < N_K; j++)
        if (k_write_strobe_i && port_id_i[j]) r_k_ports[8*j +: 8] <= out_port_i;
      r_in_port <= w_rd_data;
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (port_id_i == ADDR_STATUS) w_rd_data[N_IRQ-1:0] = w_pending;
    if (port_id_i == ADDR_MASK)   w_rd_data[N_IRQ-1:0] = w_mask;
    for (int unsigned i = 0; i < N_IN; i++)
      if (port_id_i == 8'(32'd1 << i)) w_rd_data = in_ports_i[8*i +: 8];
  end

  picoblaze_irq_ctrl #(.N_IRQ(N_IRQ)) u_irq_ctrl (
    .i_clk       (clk_i),
    .i_rst       (cpu_rst_i),
    .i_irq_req   (irq_req_i),
    .i_wdata     (out_port_i[N_IRQ-1:0]),
    .i_mask_we   (w_reg_we && port_id_i[1:0] == REG_MASK),
    .i_clear_we  (w_reg_we && port_id_i[1:0] == REG_CLEAR),
    .i_eoi_we    (w_reg_we && port_id_i[1:0] == REG_EOI),
    .i_ack       (interrupt_ack_i),
    .o_pending   (w_pending),
    .o_mask      (w_mask),
    .o_interrupt (interrupt_o)
  );

  assign out_ports_o = r_out_ports;
  assign k_ports_o   = r_k_ports;
  assign in_port_o   = r_in_port;

endmodule

// File: tb/tb_picoblaze_io_hub.sv
// Self-checking bench for picoblaze_io_hub: directed scenarios plus random
// traffic, compared every cycle against a behavioural model.
module tb_picoblaze_io_hub;

  localparam int N_IN  = 4;
  localparam int N_OUT = 4;
  localparam int N_K   = 2;
  localparam int N_IRQ = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         pid;
  logic [7:0]         data;
  logic               ws, kws, rs, ack;
  logic [7:0]         in_port;
  logic               irq_out;
  logic [N_IN*8-1:0]  in_ports;
  logic [N_OUT*8-1:0] out_ports;
  logic [N_K*8-1:0]   k_ports;
  logic [N_IRQ-1:0]   irq;

  int errors = 0;
  int checks = 0;

  // Behavioural model
  logic [7:0]       m_out [N_OUT];
  logic [7:0]       m_k   [N_K];
  logic [7:0]       m_inp;
  logic [N_IRQ-1:0] m_pend, m_mask, m_prev;
  int               m_phase;  // 0 waiting, 1 requesting, 2 being serviced

  always #5 clk = ~clk;

  picoblaze_io_hub #(.N_IN(N_IN), .N_OUT(N_OUT), .N_K(N_K), .N_IRQ(N_IRQ)) dut (
    .clk_i           (clk),
    .cpu_rst_i       (rst),
    .port_id_i       (pid),
    .out_port_i      (data),
    .write_strobe_i  (ws),
    .k_write_strobe_i(kws),
    .read_strobe_i   (rs),
    .in_port_o       (in_port),
    .interrupt_o     (irq_out),
    .interrupt_ack_i (ack),
    .in_ports_i      (in_ports),
    .out_ports_o     (out_ports),
    .k_ports_o       (k_ports),
    .irq_req_i       (irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] read_value(input logic [7:0] p);
    logic [7:0] v = 8'h00;
    if (p == 8'h80) v = 8'(m_pend);
    else if (p == 8'h81) v = 8'(m_mask);
    else for (int i = 0; i < N_IN; i++)
      if (int'(p) == (1 << i)) v = in_ports[8*i +: 8];
    return v;
  endfunction

  task automatic model_edge();
    logic [N_IRQ-1:0] clr, edges;
    logic             any_req;
    if (rst) begin
      foreach (m_out[i]) m_out[i] = 8'h00;
      foreach (m_k[i]) m_k[i] = 8'h00;
      m_inp = 8'h00; m_pend = '0; m_mask = '0; m_phase = 0;
      m_prev = irq;
      return;
    end
    m_inp = read_value(pid);
    any_req = (m_pend & m_mask) != 0;
    if (ws && !pid[7])
      for (int i = 0; i < N_OUT; i++) if (pid[i]) m_out[i] = data;
    if (kws)
      for (int j = 0; j < N_K; j++) if (pid[j]) m_k[j] = data;
    clr = (ws && pid[7] && pid[1:0] == 2'd2) ? data[N_IRQ-1:0] : '0;
    edges = irq & ~m_prev;
    m_pend = (m_pend & ~clr) | edges;
    if (ws && pid[7] && pid[1:0] == 2'd1) m_mask = data[N_IRQ-1:0];
    if (m_phase == 0 && any_req) m_phase = 1;
    else if (m_phase == 1 && ack) m_phase = 2;
    else if (m_phase == 2 && ws && pid[7] && pid[1:0] == 2'd3) m_phase = 0;
    m_prev = irq;
  endtask

  task automatic compare_all();
    for (int i = 0; i < N_OUT; i++) chk($sformatf("out%0d", i), 32'(out_ports[8*i +: 8]), 32'(m_out[i]));
    for (int j = 0; j < N_K; j++) chk($sformatf("k%0d", j), 32'(k_ports[8*j +: 8]), 32'(m_k[j]));
    chk("in_port", 32'(in_port), 32'(m_inp));
    chk("interrupt", 32'(irq_out), 32'(m_phase == 1));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic quiet();
    ws = 0; kws = 0; ack = 0; rs = 0; pid = 8'h00; data = 8'h00;
  endtask

  task automatic reg_wr(input logic [7:0] p, input logic [7:0] d);
    pid = p; data = d; ws = 1; step(); ws = 0;
  endtask

  initial begin
    rst = 1; irq = '0; in_ports = '0; quiet();
    step(); step();
    chk("rst_out", 32'(out_ports), 32'h0);
    chk("rst_irq", 32'(irq_out), 32'h0);
    rst = 0; step();

    // Single-port write and broadcast
    reg_wr(8'h04, 8'hA5);
    chk("lit_out2", 32'(out_ports[23:16]), 32'hA5);
    chk("lit_out0", 32'(out_ports[7:0]), 32'h00);
    reg_wr(8'h03, 8'h3C);
    chk("lit_bcast", 32'(out_ports[15:0]), 32'h3C3C);
    pid = 8'hF2; data = 8'h11; kws = 1; step(); kws = 0;
    chk("lit_k1", 32'(k_ports[15:8]), 32'h11);
    chk("lit_k0", 32'(k_ports[7:0]), 32'h00);

    // Read mux
    in_ports[15:8] = 8'h5A; pid = 8'h02; step();
    chk("lit_rd1", 32'(in_port), 32'h5A);
    pid = 8'h10; step();
    chk("lit_rd10", 32'(in_port), 32'h00);

    // Basic interrupt handshake
    reg_wr(8'h81, 8'h01);
    irq[0] = 1; step(); irq[0] = 0; step();
    chk("lit_irq_on", 32'(irq_out), 32'h1);
    ack = 1; step(); ack = 0;
    chk("lit_irq_ack", 32'(irq_out), 32'h0);
    reg_wr(8'h82, 8'h01); reg_wr(8'h83, 8'h00); step(); step();
    chk("lit_irq_done", 32'(irq_out), 32'h0);

    // Edge beats clear; EOI with bit still pending re-requests
    reg_wr(8'h81, 8'h04);
    irq[2] = 1; step(); irq[2] = 0; step(); step();
    ack = 1; step(); ack = 0;
    irq[2] = 1; reg_wr(8'h82, 8'h04); irq[2] = 0;
    pid = 8'h80; step();
    chk("lit_status", 32'(in_port), 32'h04);
    reg_wr(8'h83, 8'h00);
    chk("lit_eoi_idle", 32'(irq_out), 32'h0);
    quiet(); step();
    chk("lit_reassert", 32'(irq_out), 32'h1);
    ack = 1; step(); ack = 0;
    reg_wr(8'h82, 8'h0F); reg_wr(8'h83, 8'h00); step();

    // Source held high through reset release
    irq[0] = 1; rst = 1; step(); step(); rst = 0;
    reg_wr(8'h81, 8'h01);
    pid = 8'h80; step(); step();
    chk("lit_no_edge", 32'(in_port), 32'h00);
    chk("lit_no_irq", 32'(irq_out), 32'h0);

    // Reset in service
    irq[0] = 0; step(); irq[0] = 1; step(); step();
    ack = 1; step(); ack = 0;
    rst = 1; step(); rst = 0; irq[0] = 0;
    chk("lit_rst_svc", 32'(irq_out), 32'h0);
    pid = 8'h80; step(); step();
    chk("lit_rst_pend", 32'(in_port), 32'h00);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 5))
        0: pid = 8'($urandom);
        1: pid = 8'(1 << $urandom_range(0, 7));
        2: pid = 8'h80 | 8'($urandom_range(0, 3));
        3: pid = 8'hF0 | 8'($urandom_range(0, 15));
        default: pid = 8'($urandom_range(0, 15));
      endcase
      data = 8'($urandom);
      ws   = ($urandom_range(0, 3) == 0);
      kws  = ($urandom_range(0, 4) == 0);
      rs   = 1'($urandom);
      ack  = ($urandom_range(0, 2) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) == 0) irq = irq ^ N_IRQ'(1 << $urandom_range(0, N_IRQ-1));
      if ($urandom_range(0, 7) == 0) in_ports = {$urandom};
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
